// File: rtl/stereo_line_scheduler.sv
`default_nettype none
// stereo_line_scheduler: interleaves left/right camera lines (L0 R0 L1 R1 ...) into one
// registered valid/ready stream with source tag, frame/line markers and position counters.  Rev 1.0
module stereo_line_scheduler #(
  parameter int DATA_WIDTH     = 8,
  parameter int LINE_PIXELS    = 640,
  parameter int FRAME_LINES    = 480,
  parameter int PIX_CNT_WIDTH  = 10,
  parameter int LINE_CNT_WIDTH = 9
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      l_valid,
  input  logic [DATA_WIDTH-1:0]     l_data,
  output logic                      l_ready,
  input  logic                      r_valid,
  input  logic [DATA_WIDTH-1:0]     r_data,
  output logic                      r_ready,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_data,
  input  logic                      out_ready,
  output logic                      out_sel,
  output logic                      out_sof,
  output logic                      out_eol,
  output logic [PIX_CNT_WIDTH-1:0]  pix_count,
  output logic [LINE_CNT_WIDTH-1:0] line_count,
  output logic                      frame_done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LEFT      = 2'd1,
    RIGHT     = 2'd2,
    FRAME_END = 2'd3
  } state_t;

  localparam logic [PIX_CNT_WIDTH-1:0]  PIX_LAST  = PIX_CNT_WIDTH'(LINE_PIXELS - 1);
  localparam logic [PIX_CNT_WIDTH-1:0]  PIX_ONE   = PIX_CNT_WIDTH'(1);
  localparam logic [LINE_CNT_WIDTH-1:0] LINE_LAST = LINE_CNT_WIDTH'(FRAME_LINES - 1);
  localparam logic [LINE_CNT_WIDTH-1:0] LINE_ONE  = LINE_CNT_WIDTH'(1);

  state_t state;
  state_t state_next;
  logic   stage_free;
  logic   l_acc;
  logic   r_acc;
  logic   accept;
  logic   last_pix;
  logic   last_line;

  // The output register can take a new beat whenever the held one leaves this cycle.
  assign stage_free = !out_valid || out_ready;
  assign l_ready    = (state == LEFT)  && stage_free;
  assign r_ready    = (state == RIGHT) && stage_free;
  assign l_acc      = l_valid && l_ready;
  assign r_acc      = r_valid && r_ready;
  assign accept     = l_acc || r_acc;
  assign last_pix   = (pix_count == PIX_LAST);
  assign last_line  = (line_count == LINE_LAST);
  assign frame_done = (state == FRAME_END);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (enable) state_next = LEFT;
      LEFT:      if (l_acc && last_pix) state_next = RIGHT;
      RIGHT:     if (r_acc && last_pix) state_next = last_line ? FRAME_END : LEFT;
      FRAME_END: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pix_count  <= '0;
      line_count <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= 1'b0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        pix_count  <= '0;
        line_count <= '0;
      end
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= r_acc ? r_data : l_data;
        out_sel   <= r_acc;
        out_sof   <= l_acc && (line_count == '0) && (pix_count == '0);
        out_eol   <= last_pix;
        pix_count <= last_pix ? '0 : pix_count + PIX_ONE;
        // Line advances only once both cameras have delivered the line.
        if (r_acc && last_pix) begin
          line_count <= last_line ? '0 : line_count + LINE_ONE;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stereo_line_scheduler.sv
`default_nettype none
// tb_stereo_line_scheduler: directed scoreboard bench for stereo_line_scheduler (4 px x 2 lines).
module tb_stereo_line_scheduler;

  localparam int DW = 8;
  localparam int LP = 4;
  localparam int FL = 2;
  localparam int PW = 3;
  localparam int LW = 2;

  typedef struct packed {
    logic          sel;
    logic          sof;
    logic          eol;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset, enable, l_valid, r_valid, out_ready;
  logic [DW-1:0] l_data, r_data;
  logic          l_ready, r_ready, out_valid, out_sel, out_sof, out_eol, frame_done;
  logic [DW-1:0] out_data;
  logic [PW-1:0] pix_count;
  logic [LW-1:0] line_count;

  stereo_line_scheduler #(
    .DATA_WIDTH(DW), .LINE_PIXELS(LP), .FRAME_LINES(FL),
    .PIX_CNT_WIDTH(PW), .LINE_CNT_WIDTH(LW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .l_valid(l_valid), .l_data(l_data), .l_ready(l_ready),
    .r_valid(r_valid), .r_data(r_data), .r_ready(r_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_sel(out_sel), .out_sof(out_sof), .out_eol(out_eol),
    .pix_count(pix_count), .line_count(line_count), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];

  // Stimulus controls and the bench's own frame-position model.
  logic rst_drv = 1'b1, en_drv = 1'b0, lv_en = 1'b1, rv_en = 1'b1, ordy = 1'b1;
  logic m_side = 1'b0;
  int   m_pix = 0, m_line = 0, l_pix = 0, r_pix = 0;
  logic done_pending = 1'b0;
  int   cyc = 0, frames = 0, frame_acc = 0, acc_total = 0;
  int   done_cyc = 0, sof_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    beat_t got, e;
    logic  acc_l, acc_r;
    @(negedge clk);
    reset     = rst_drv;
    enable    = en_drv;
    out_ready = ordy;
    l_valid   = lv_en;
    r_valid   = rv_en;
    l_data    = DW'(32'h10 + l_pix);
    r_data    = DW'(32'h20 + r_pix);
    #1;
    cyc++;
    if (!rst_drv) begin
      got = {out_sel, out_sof, out_eol, out_data};
      chk("frame_done", 32'(frame_done), 32'(done_pending));
      if (done_pending) begin
        frames++;
        done_cyc = cyc;
      end
      done_pending = 1'b0;
      chk("pix_count", 32'(pix_count), 32'(m_pix));
      chk("line_count", 32'(line_count), 32'(m_line));
      chk("ready_exclusive", 32'(l_ready && r_ready), 32'd0);
      if (m_side) chk("l_ready_wrong_side", 32'(l_ready), 32'd0);
      else        chk("r_ready_wrong_side", 32'(r_ready), 32'd0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(out_valid), 32'd0);
        end else begin
          chk(out_ready ? "beat" : "held_beat", 32'(got), 32'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
        if (!out_ready) chk("stall_l_ready", 32'(l_ready), 32'd0);
      end
      acc_l = l_valid && l_ready;
      acc_r = r_valid && r_ready;
      if (acc_l || acc_r) begin
        chk("accept_side", 32'(acc_r), 32'(m_side));
        e.sel  = m_side;
        e.sof  = !m_side && (m_line == 0) && (m_pix == 0);
        e.eol  = (m_pix == LP - 1);
        e.data = m_side ? DW'(32'h20 + m_pix) : DW'(32'h10 + m_pix);
        exp_q.push_back(e);
        if (e.sof) sof_cyc = cyc;
        acc_total++;
        frame_acc++;
        if (acc_l) l_pix = (l_pix + 1) % LP;
        if (acc_r) r_pix = (r_pix + 1) % LP;
        if (m_pix == LP - 1) begin
          m_pix = 0;
          if (!m_side) begin
            m_side = 1'b1;
          end else begin
            m_side = 1'b0;
            if (m_line == FL - 1) begin
              m_line       = 0;
              done_pending = 1'b1;
              frame_acc    = 0;
            end else begin
              m_line++;
            end
          end
        end else begin
          m_pix++;
        end
      end
    end
  endtask

  task automatic run_frames(input int target, input int budget);
    int n = 0;
    while (frames < target && n < budget) begin
      step();
      n++;
    end
    if (frames < target) chk("frame_timeout", 32'(frames), 32'(target));
  endtask

  task automatic run_accepts(input int target, input int budget);
    int n = 0;
    while (frame_acc < target && n < budget) begin
      step();
      n++;
    end
    if (frame_acc < target) chk("accept_timeout", 32'(frame_acc), 32'(target));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_out_tags"}, 32'({out_sel, out_sof, out_eol}), 32'd0);
    chk({tag, "_pix_count"}, 32'(pix_count), 32'd0);
    chk({tag, "_line_count"}, 32'(line_count), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_readies"}, 32'({l_ready, r_ready}), 32'd0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; l_valid = 1'b0; r_valid = 1'b0;
    l_data = '0; r_data = '0; out_ready = 1'b1;

    // Reset state, with both valids asserted to show nothing is accepted.
    step();
    step();
    check_idle("reset");
    rst_drv = 1'b0;

    // Full frame with enable held high over the boundary into a second frame.
    en_drv = 1'b1;
    run_frames(1, 100);
    chk("frame1_accepts", 32'(acc_total), 32'(2 * LP * FL));
    run_accepts(1, 20);
    chk("sof_gap", 32'(sof_cyc - done_cyc), 32'd2);

    // Enable dropped after sof: the frame still completes, then no restart.
    en_drv = 1'b0;
    run_frames(2, 100);
    repeat (10) step();
    chk("no_restart_accepts", 32'(acc_total), 32'(4 * LP * FL));
    chk("drain_frame2", 32'(exp_q.size()), 32'd0);

    // Backpressure for 5 cycles mid-line.
    en_drv = 1'b1;
    run_accepts(1, 20);
    en_drv = 1'b0;
    run_accepts(6, 40);
    ordy = 1'b0;
    repeat (5) step();
    ordy = 1'b1;
    run_frames(3, 100);
    repeat (4) step();
    chk("drain_frame3", 32'(exp_q.size()), 32'd0);
    chk("frame3_accepts", 32'(acc_total), 32'(6 * LP * FL));

    // Reset with the 6th beat of the frame in flight, then a clean restart.
    en_drv = 1'b1;
    run_accepts(6, 40);
    rst_drv = 1'b1;
    step();
    rst_drv = 1'b0;
    exp_q.delete();
    m_side = 1'b0; m_pix = 0; m_line = 0; l_pix = 0; r_pix = 0;
    done_pending = 1'b0; frame_acc = 0;
    step();
    check_idle("post_reset");
    run_accepts(1, 20);
    en_drv = 1'b0;
    run_frames(4, 100);
    repeat (4) step();
    chk("drain_frame4", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stereo_line_scheduler.md
Name: stereo_line_scheduler

Overview:
- Sequences the left and right camera pixel streams into the single encryption datapath, one line at a time.
- Order per frame: line 0 left, line 0 right, line 1 left, line 1 right, and so on.
- Keeps the pixel and line counters that tell the encryptor where each beat sits in the frame.
- Drives one registered valid/ready output stage with source tag and frame/line markers.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- LINE_PIXELS, 640, pixels per line per camera.
- FRAME_LINES, 480, lines per frame per camera.
- PIX_CNT_WIDTH, 10, width of pix_count; must satisfy 2^PIX_CNT_WIDTH >= LINE_PIXELS.
- LINE_CNT_WIDTH, 9, width of line_count; must satisfy 2^LINE_CNT_WIDTH >= FRAME_LINES.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: permits a new frame to start; sampled only in IDLE.
- l_valid, input, 1: left pixel available.
- l_data, input, DATA_WIDTH: left pixel.
- l_ready, output, 1: left pixel accepted when l_valid && l_ready.
- r_valid, input, 1: right pixel available.
- r_data, input, DATA_WIDTH: right pixel.
- r_ready, output, 1: right pixel accepted when r_valid && r_ready.
- out_valid, output, 1: output beat held.
- out_data, output, DATA_WIDTH: registered pixel.
- out_ready, input, 1: downstream accepts the beat.
- out_sel, output, 1: source of the current beat; 0 = left, 1 = right.
- out_sof, output, 1: beat is left pixel 0 of line 0.
- out_eol, output, 1: beat is the last pixel of a line, either side.
- pix_count, output, PIX_CNT_WIDTH: index of the next pixel to accept.
- line_count, output, LINE_CNT_WIDTH: current line index.
- frame_done, output, 1: one-cycle pulse when the frame completes.

Behaviour:
Reset
- Everything is synchronous: reset is sampled on the rising edge of clk and takes priority over all other activity.
- Reset values: state = IDLE; pix_count = 0; line_count = 0; out_valid = 0; out_data = 0; out_sel = 0; out_sof = 0; out_eol = 0; frame_done = 0; l_ready = 0; r_ready = 0.
- Reset mid-frame discards any held beat and drops in-flight line progress immediately. No partial-frame completion and no frame_done.

Output stage
- out_stage_free = !out_valid || out_ready.
- l_ready = (state == LEFT) && out_stage_free. r_ready = (state == RIGHT) && out_stage_free. Both are combinational, and never high together.
- On an accepted input, the next edge loads out_data, out_sel, out_sof and out_eol, and sets out_valid = 1. Latency is 1 cycle from input accept to out_valid.
- If out_valid && out_ready and no new accept happens, out_valid clears at the edge.
- While out_valid && !out_ready, out_data, out_sel, out_sof and out_eol hold stable.
- A new accept is allowed in the same cycle the held beat is consumed. Full throughput is 1 beat/cycle.

FSM
- IDLE: if enable == 1, go to LEFT next cycle; pix_count = 0, line_count = 0. Otherwise stay in IDLE.
- LEFT: on each left accept, pix_count increments. On the accept at pix_count == LINE_PIXELS-1:
  - out_eol = 1 for that beat;
  - pix_count wraps to 0;
  - state goes to RIGHT.
- RIGHT: same rules for right accepts. On the last accept:
  - pix_count wraps to 0;
  - if line_count == FRAME_LINES-1, line_count wraps to 0 and state goes to FRAME_END;
  - otherwise line_count increments and state goes to LEFT.
- FRAME_END: lasts exactly one cycle. frame_done = 1 in that cycle, then state returns to IDLE.
  - Nothing is accepted in FRAME_END.
  - The last beat may still be held in the output stage.

Boundary rules
- out_sof = 1 only for the beat accepted with state == LEFT, line_count == 0, pix_count == 0.
- Deasserting enable mid-frame has no effect: the frame completes, then the block stays in IDLE.
- Idle valid on the non-selected side is ignored; that side sees ready = 0 and its data is never dropped.
- Back-to-back frames: with enable held high, the path is FRAME_END -> IDLE -> LEFT, a minimum 2-cycle gap between frames.
- Counter arithmetic is unsigned and modulo the limits above. pix_count and line_count never reach LINE_PIXELS or FRAME_LINES.

Test Plan:
All tests use LINE_PIXELS=4, FRAME_LINES=2, DATA_WIDTH=8.
1. Full frame, constant valids and out_ready=1: left 0x10..0x13 and right 0x20..0x23 per line, enable=1.
   - Output order: L0 R0 L1 R1, 16 beats.
   - out_sof only on the first beat; out_eol on beats 4, 8, 12, 16.
   - frame_done pulses once, 1 cycle after the 16th accept.
2. Backpressure: out_ready=0 for 5 cycles mid-line.
   - out_data holds stable; l_ready=0; no beats lost or duplicated; pix_count frozen.
3. Wrong-side traffic: r_valid=1 while in LEFT.
   - r_ready stays 0; right data is taken only after the 4th left beat.
4. Reset at the 6th accepted beat.
   - Next cycle: out_valid=0, pix_count=0, line_count=0, state IDLE.
   - Restarted frame outputs out_sof on its first beat.
5. enable dropped after sof.
   - All 16 beats complete; frame_done pulses; no new frame starts while enable=0.
6. enable held high over the frame boundary.
   - Second-frame sof appears exactly 2 cycles after frame_done.
